// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared widths, FSM states and sign helpers for the ex_div divider
package ex_div_pkg;
  localparam int REG_W = 32;
  localparam int DREG_W = 64;
  localparam logic [REG_W-1:0] ZERO_WORD = '0;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;
  function automatic logic [REG_W-1:0] neg_if(input logic [REG_W-1:0] x, input logic n);
    return n ? -x : x;
  endfunction
  function automatic logic [REG_W-1:0] mag(input logic [REG_W-1:0] x);
    return neg_if(x, x[REG_W-1]);
  endfunction
endpackage

// File: rtl/ex_div_step.sv
// ex_div_step: one restoring iteration on the {remainder, quotient} partial
module ex_div_step
  import ex_div_pkg::*;
(
  input  logic [DREG_W-1:0] partial,
  input  logic [REG_W-1:0]  divisor,
  output logic [DREG_W-1:0] next
);
  logic [DREG_W-1:0] sh;
  logic [REG_W:0] trial;
  assign sh = {partial[DREG_W-2:0], 1'b0};
  assign trial = {1'b0, sh[DREG_W-1:REG_W]} - {1'b0, divisor};
  assign next = trial[REG_W] ? sh : {trial[REG_W-1:0], sh[REG_W-1:1], 1'b1};
endmodule

// File: rtl/ex_div.sv
// ex_div: iterative 32-bit radix-2 restoring divider for the EX stage
// DIV_ZERO_SKIP_EN: short-circuit a zero divisor through DIV_BY_ZERO
module ex_div
  import ex_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_div_i,
  input  logic [REG_W-1:0]  opdata1_i,
  input  logic [REG_W-1:0]  opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [DREG_W-1:0] result_o,
  output logic              ready_o
);
  div_state_t state;
  logic [4:0] cnt;
  logic [REG_W-1:0] divisor;
  logic [DREG_W-1:0] partial, step_out;
  logic qsign, rsign;
  ex_div_step u_step (.partial(partial), .divisor(divisor), .next(step_out));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= DIV_FREE;
      cnt <= '0;
      divisor <= '0;
      partial <= '0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      ready_o <= 1'b0;
      result_o <= '0;
    end else
      case (state)
        DIV_FREE:
          if (start_i && !annul_i) begin
            partial <= {ZERO_WORD, signed_div_i ? mag(opdata1_i) : opdata1_i};
            divisor <= signed_div_i ? mag(opdata2_i) : opdata2_i;
            qsign <= signed_div_i & (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
            rsign <= signed_div_i & opdata1_i[REG_W-1];
            cnt <= '0;
`ifdef DIV_ZERO_SKIP_EN
            state <= opdata2_i == ZERO_WORD ? DIV_BY_ZERO : DIV_ON;
`else
            state <= DIV_ON;
`endif
          end else begin
            ready_o <= 1'b0;
            result_o <= '0;
          end
`ifdef DIV_ZERO_SKIP_EN
        DIV_BY_ZERO: begin
          state <= DIV_END;
          ready_o <= 1'b1;
          result_o <= '0;
        end
`endif
        DIV_ON:
          if (annul_i) begin
            state <= DIV_FREE;
            ready_o <= 1'b0;
            result_o <= '0;
          end else begin
            partial <= step_out;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state <= DIV_END;
              ready_o <= 1'b1;
              result_o <= {neg_if(step_out[DREG_W-1:REG_W], rsign), neg_if(step_out[REG_W-1:0], qsign)};
            end
          end
        DIV_END:
          if (!start_i) begin
            state <= DIV_FREE;
            ready_o <= 1'b0;
            result_o <= '0;
          end
        default: state <= DIV_FREE;
      endcase
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div
module tb_ex_div;
  logic clk = 1'b0, rst = 1'b0, signed_div_i = 1'b0, start_i = 1'b0, annul_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic [63:0] result_o;
  logic ready_o;
  int errors = 0, checks = 0;
  ex_div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int lat);
    int n;
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
    n = 0;
    while (!ready_o && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " result"}, result_o, exp);
    @(posedge clk); #1;
    chk({tag, " hold ready"}, 64'(ready_o), 64'd1);
    chk({tag, " hold result"}, result_o, exp);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, " drop ready"}, 64'(ready_o), 64'd0);
    chk({tag, " drop result"}, result_o, 64'd0);
  endtask
  initial begin
    int n;
    logic seen;
    #2 rst = 1'b1;
    #2;
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 32);
    run("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32);
    run("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 32);
    run("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 32);
    run("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 32);
    run("div -9/-4", 1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFC, {32'hFFFF_FFFF, 32'h2}, 32);
    run("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 32);
`ifdef DIV_ZERO_SKIP_EN
    run("divu 5/0", 1'b0, 32'd5, 32'd0, 64'd0, 1);
`else
    run("divu 5/0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 32);
`endif
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    seen = ready_o;
    repeat (40) begin @(posedge clk); #1; seen |= ready_o; end
    chk("annul no ready", 64'(seen), 64'd0);
    run("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (15) begin @(posedge clk); #1; end
    #2 rst = 1'b1; start_i = 1'b0;
    #1;
    chk("async rst mid ready", 64'(ready_o), 64'd0);
    chk("async rst mid result", result_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run("divu 100/7 after rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 32);
    signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!ready_o && n < 40) begin @(posedge clk); #1; n++; end
    chk("pre-rst ready", 64'(ready_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst end ready", 64'(ready_o), 64'd0);
    chk("async rst end result", result_o, 64'd0);
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    chk("idle after rst ready", 64'(ready_o), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
